key_event: RTL and testbench

Key-event decoder placed directly downstream of the 2-key debouncer. It consumes the debounced, active-high "key held" levels and turns them into one-cycle event pulses that UI/menu logic can act on: press, short click, long press, auto-repeat, release, and a two-key combo. Each key runs an independent hold-timing state machine with a per-key millisecond prescaler, so long-press and repeat timing is cycle-exact relative to the press.

---
 rtl/key_event.sv | 158 +++++++++++++++
 tb/tb_key_event.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
`timescale 1ns/1ps
// Two-key event decoder: turns debounced "key held" levels into one-cycle
// press / click / long / repeat / release pulses plus a two-key combo pulse.
module key_event #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_in,
  output logic [1:0] press_pulse,
  output logic [1:0] click_pulse,
  output logic [1:0] long_pulse,
  output logic [1:0] repeat_pulse,
  output logic [1:0] release_pulse,
  output logic [1:0] long_hold,
  output logic       combo_pulse
);

  localparam int CPM    = CLK_HZ / 1000;
  localparam int SUB_W  = (CPM > 1) ? $clog2(CPM) : 1;
  localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int MS_W   = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CPM - 1);
  localparam logic [SUB_W-1:0] SUB_ZERO  = SUB_W'(0);
  localparam logic [SUB_W-1:0] SUB_ONE   = SUB_W'(1);
  localparam logic [MS_W-1:0]  MS_ZERO   = MS_W'(0);
  localparam logic [MS_W-1:0]  MS_ONE    = MS_W'(1);
  localparam logic [MS_W-1:0]  LONG_LAST = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0]  REP_LAST  = MS_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  state_t           r_state [2];
  logic [SUB_W-1:0] r_sub   [2];
  logic [MS_W-1:0]  r_ms    [2];
  logic [1:0]       r_prev;
  logic             r_both;

  logic [1:0] w_rise;
  logic [1:0] w_fall;
  logic [1:0] w_sub_wrap;
  logic [1:0] w_long_hit;
  logic [1:0] w_rep_hit;
  logic [1:0] w_busy_next;

  // Edge detection, threshold decode and next-cycle "key active" flags.
  always_comb begin
    w_rise      = key_in & ~r_prev;
    w_fall      = ~key_in & r_prev;
    w_sub_wrap  = 2'b00;
    w_long_hit  = 2'b00;
    w_rep_hit   = 2'b00;
    w_busy_next = 2'b00;
    for (int k = 0; k < 2; k++) begin
      w_sub_wrap[k]  = (r_sub[k] == SUB_LAST);
      w_long_hit[k]  = w_sub_wrap[k] && (r_ms[k] == LONG_LAST);
      w_rep_hit[k]   = w_sub_wrap[k] && (r_ms[k] == REP_LAST);
      // Only a fall leaves PRESSED/LONG, only a rise leaves IDLE.
      w_busy_next[k] = (r_state[k] == ST_IDLE) ? w_rise[k] : ~w_fall[k];
    end
  end

  // Per-key hold-timing FSMs, combo tracking and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev        <= 2'b11;
      r_both        <= 1'b0;
      combo_pulse   <= 1'b0;
      press_pulse   <= 2'b00;
      click_pulse   <= 2'b00;
      long_pulse    <= 2'b00;
      repeat_pulse  <= 2'b00;
      release_pulse <= 2'b00;
      long_hold     <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= ST_IDLE;
        r_sub[k]   <= SUB_ZERO;
        r_ms[k]    <= MS_ZERO;
      end
    end else begin
      r_prev        <= key_in;
      r_both        <= &w_busy_next;
      combo_pulse   <= (&w_busy_next) & ~r_both;
      press_pulse   <= 2'b00;
      click_pulse   <= 2'b00;
      long_pulse    <= 2'b00;
      repeat_pulse  <= 2'b00;
      release_pulse <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        case (r_state[k])
          ST_IDLE: begin
            if (w_rise[k]) begin
              r_state[k]     <= ST_PRESSED;
              r_sub[k]       <= SUB_ZERO;
              r_ms[k]        <= MS_ZERO;
              press_pulse[k] <= 1'b1;
            end else begin
              r_state[k] <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            // A release in the threshold cycle still counts as a click.
            if (w_fall[k]) begin
              r_state[k]       <= ST_IDLE;
              r_sub[k]         <= SUB_ZERO;
              r_ms[k]          <= MS_ZERO;
              click_pulse[k]   <= 1'b1;
              release_pulse[k] <= 1'b1;
            end else if (w_long_hit[k]) begin
              r_state[k]    <= ST_LONG;
              r_sub[k]      <= SUB_ZERO;
              r_ms[k]       <= MS_ZERO;
              long_pulse[k] <= 1'b1;
              long_hold[k]  <= 1'b1;
            end else if (w_sub_wrap[k]) begin
              r_sub[k] <= SUB_ZERO;
              r_ms[k]  <= r_ms[k] + MS_ONE;
            end else begin
              r_sub[k] <= r_sub[k] + SUB_ONE;
            end
          end
          ST_LONG: begin
            if (w_fall[k]) begin
              r_state[k]       <= ST_IDLE;
              r_sub[k]         <= SUB_ZERO;
              r_ms[k]          <= MS_ZERO;
              release_pulse[k] <= 1'b1;
              long_hold[k]     <= 1'b0;
            end else if (w_rep_hit[k]) begin
              r_sub[k]        <= SUB_ZERO;
              r_ms[k]         <= MS_ZERO;
              repeat_pulse[k] <= 1'b1;
            end else if (w_sub_wrap[k]) begin
              r_sub[k] <= SUB_ZERO;
              r_ms[k]  <= r_ms[k] + MS_ONE;
            end else begin
              r_sub[k] <= r_sub[k] + SUB_ONE;
            end
          end
          default: begin
            r_state[k]   <= ST_IDLE;
            r_sub[k]     <= SUB_ZERO;
            r_ms[k]      <= MS_ZERO;
            long_hold[k] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_event.sv
`timescale 1ns/1ps
// Bench for key_event: a hold-age reference model feeds a per-cycle scoreboard,
// and a segment table checks hand-computed pulse counts per stimulus segment.
module tb_key_event;

  localparam int CLK_HZ    = 10000;
  localparam int LONG_MS   = 5;
  localparam int REPEAT_MS = 2;
  localparam int CPM       = CLK_HZ / 1000;

  logic       clk;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, long_hold;
  logic       combo_pulse;

  key_event #(.CLK_HZ(CLK_HZ), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .press_pulse  (press_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .long_hold    (long_hold),
    .combo_pulse  (combo_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cb;
    logic [1:0] lh;
    logic [1:0] rl;
    logic [1:0] rp;
    logic [1:0] lg;
    logic [1:0] ck;
    logic [1:0] pr;
  } outs_t;

  // Count index: 0/1 press, 2/3 click, 4/5 long, 6/7 repeat, 8/9 release, 10 combo
  typedef struct {
    logic [1:0]      key;
    int              cycles;
    logic [10:0][3:0] exp;
  } seg_t;

  string cnt_name [11] = '{"press0", "press1", "click0", "click1", "long0", "long1",
                           "repeat0", "repeat1", "release0", "release1", "combo"};

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    cnt [11];
  outs_t sb_q [$];

  // Reference model state: hold age since the press pulse, age since long/repeat.
  logic [1:0] m_prev;
  logic [1:0] m_busy;
  logic [1:0] m_long;
  logic       m_both;
  int         m_age  [2];
  int         m_lage [2];

  function automatic outs_t cur_outs();
    return {combo_pulse, long_hold, release_pulse, repeat_pulse,
            long_pulse, click_pulse, press_pulse};
  endfunction

  task automatic model_reset();
    m_prev = 2'b11;
    m_busy = 2'b00;
    m_long = 2'b00;
    m_both = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_age[k]  = 0;
      m_lage[k] = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] v, output outs_t e);
    logic both;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k]) begin
        if (v[k] && !m_prev[k]) begin
          m_busy[k] = 1'b1;
          m_age[k]  = 0;
          e.pr[k]   = 1'b1;
        end
      end else begin
        m_age[k] = m_age[k] + 1;
        if (!v[k] && m_prev[k]) begin
          e.rl[k]   = 1'b1;
          e.ck[k]   = ~m_long[k];
          m_busy[k] = 1'b0;
          m_long[k] = 1'b0;
        end else if (!m_long[k]) begin
          if (m_age[k] == LONG_MS * CPM) begin
            e.lg[k]   = 1'b1;
            m_long[k] = 1'b1;
            m_lage[k] = 0;
          end
        end else begin
          m_lage[k] = m_lage[k] + 1;
          if (m_lage[k] == REPEAT_MS * CPM) begin
            e.rp[k]   = 1'b1;
            m_lage[k] = 0;
          end
        end
      end
      e.lh[k] = m_long[k];
    end
    both   = m_busy[0] & m_busy[1];
    e.cb   = both & ~m_both;
    m_both = both;
    m_prev = v;
  endtask

  task automatic step(input logic [1:0] k);
    outs_t e;
    outs_t a;
    @(negedge clk);
    key_in = k;
    model_step(k, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    a = cur_outs();
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty cycle %0d: got %b, nothing expected", cyc, a);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL sb cycle %0d key %b: got %b want %b", cyc, k, a, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (a.pr[i]) cnt[0 + i]++;
      if (a.ck[i]) cnt[2 + i]++;
      if (a.lg[i]) cnt[4 + i]++;
      if (a.rp[i]) cnt[6 + i]++;
      if (a.rl[i]) cnt[8 + i]++;
    end
    if (a.cb) cnt[10]++;
  endtask

  task automatic run_seg(input string tag, input seg_t s);
    for (int j = 0; j < 11; j++) cnt[j] = 0;
    for (int i = 0; i < s.cycles; i++) step(s.key);
    for (int j = 0; j < 11; j++) begin
      checks++;
      if (cnt[j] != int'(s.exp[j])) begin
        errors++;
        $display("FAIL %s %s count: got %0d want %0d", tag, cnt_name[j], cnt[j], s.exp[j]);
      end
    end
  endtask

  function automatic seg_t mk(input logic [1:0] key, input int cycles,
                              input int p0, input int p1, input int c0, input int c1,
                              input int l0, input int l1, input int r0, input int r1,
                              input int rl0, input int rl1, input int cb);
    seg_t s;
    s.key     = key;
    s.cycles  = cycles;
    s.exp[0]  = 4'(p0);  s.exp[1]  = 4'(p1);
    s.exp[2]  = 4'(c0);  s.exp[3]  = 4'(c1);
    s.exp[4]  = 4'(l0);  s.exp[5]  = 4'(l1);
    s.exp[6]  = 4'(r0);  s.exp[7]  = 4'(r1);
    s.exp[8]  = 4'(rl0); s.exp[9]  = 4'(rl1);
    s.exp[10] = 4'(cb);
    return s;
  endfunction

  task automatic check_zero(input string tag);
    outs_t a;
    a = cur_outs();
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s: got %b want all zero", tag, a);
    end
  endtask

  task automatic do_reset(input logic [1:0] k);
    @(negedge clk);
    key_in = k;
    rst    = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
  endtask

  seg_t tbl [21];

  initial begin
    rst    = 1'b1;
    key_in = 2'b00;
    model_reset();

    tbl[0]  = mk(2'b00,   5, 0,0, 0,0, 0,0, 0,0, 0,0, 0);
    tbl[1]  = mk(2'b01,  30, 1,0, 0,0, 0,0, 0,0, 0,0, 0);   // short click
    tbl[2]  = mk(2'b00,  10, 0,0, 1,0, 0,0, 0,0, 1,0, 0);
    tbl[3]  = mk(2'b10, 120, 0,1, 0,0, 0,1, 0,3, 0,0, 0);   // long + repeats
    tbl[4]  = mk(2'b00,  10, 0,0, 0,0, 0,0, 0,0, 0,1, 0);
    tbl[5]  = mk(2'b01,  49, 1,0, 0,0, 0,0, 0,0, 0,0, 0);
    tbl[6]  = mk(2'b00,  10, 0,0, 1,0, 0,0, 0,0, 1,0, 0);
    tbl[7]  = mk(2'b01,  50, 1,0, 0,0, 0,0, 0,0, 0,0, 0);   // fall on threshold cycle
    tbl[8]  = mk(2'b00,   5, 0,0, 1,0, 0,0, 0,0, 1,0, 0);
    tbl[9]  = mk(2'b01,  51, 1,0, 0,0, 1,0, 0,0, 0,0, 0);   // one cycle past threshold
    tbl[10] = mk(2'b00,   5, 0,0, 0,0, 0,0, 0,0, 1,0, 0);
    tbl[11] = mk(2'b01,   7, 1,0, 0,0, 0,0, 0,0, 0,0, 0);   // combo sequence
    tbl[12] = mk(2'b11,  20, 0,1, 0,0, 0,0, 0,0, 0,0, 1);
    tbl[13] = mk(2'b01,   5, 0,0, 0,1, 0,0, 0,0, 0,1, 0);
    tbl[14] = mk(2'b11,  10, 0,1, 0,0, 0,0, 0,0, 0,0, 1);
    tbl[15] = mk(2'b00,   5, 0,0, 1,1, 0,0, 0,0, 1,1, 0);
    tbl[16] = mk(2'b11,   3, 1,1, 0,0, 0,0, 0,0, 0,0, 1);   // simultaneous rises
    tbl[17] = mk(2'b00,   3, 0,0, 1,1, 0,0, 0,0, 1,1, 0);
    tbl[18] = mk(2'b01,  60, 1,0, 0,0, 1,0, 0,0, 0,0, 0);
    tbl[19] = mk(2'b11,   5, 0,1, 0,0, 0,0, 0,0, 0,0, 1);   // combo while key0 long
    tbl[20] = mk(2'b00,   3, 0,0, 0,1, 0,0, 0,0, 1,1, 0);

    do_reset(2'b00);
    for (int i = 0; i < 21; i++) run_seg($sformatf("seg%0d", i), tbl[i]);

    // Key held across reset deassertion: no press until released and re-pressed.
    do_reset(2'b01);
    run_seg("hold_rst_a", mk(2'b01, 5, 0,0, 0,0, 0,0, 0,0, 0,0, 0));
    run_seg("hold_rst_b", mk(2'b00, 5, 0,0, 0,0, 0,0, 0,0, 0,0, 0));
    run_seg("hold_rst_c", mk(2'b01, 3, 1,0, 0,0, 0,0, 0,0, 0,0, 0));
    run_seg("hold_rst_d", mk(2'b00, 3, 0,0, 1,0, 0,0, 0,0, 1,0, 0));

    // Reset asserted mid-cycle while key1 is in LONG: outputs clear at once.
    run_seg("mid_long", mk(2'b10, 60, 0,1, 0,0, 0,1, 0,0, 0,0, 0));
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seg("post_rst_a", mk(2'b10, 5, 0,0, 0,0, 0,0, 0,0, 0,0, 0));
    run_seg("post_rst_b", mk(2'b00, 5, 0,0, 0,0, 0,0, 0,0, 0,0, 0));
    run_seg("post_rst_c", mk(2'b10, 3, 0,1, 0,0, 0,0, 0,0, 0,0, 0));
    run_seg("post_rst_d", mk(2'b00, 3, 0,0, 0,1, 0,0, 0,0, 0,1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
